calc_share_arbiter: RTL and testbench
=====================================

// Module: calc_share_arbiter
// PURPOSE
//  Shares one fixed-latency dot-product calc unit ({VecA,VecB,Bias} -> 1 word) between NREQ layer
//  controllers (conv, dense). Round-robin grant, one issue per cycle; each issue carries a requester
//  tag down a latency-matched pipeline so the result returns only to the requester that issued it.
//  Sits between the layer blocks and the single calc instance in the full design.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  WIDTH    16  word width
//  VEC_LEN  25  words per vector; calc operand = WIDTH*(2*VEC_LEN+1) bits
//  CALC_LAT 7   cycles from calc_valid_o/calc_data_o to matching calc_result_i (>=1)
// PORTS
//  clk           in   1                        clock, all logic on rising edge
//  rst           in   1                        synchronous, active-high reset
//  req_valid_i   in   NREQ                     requester i has an operand ready
//  req_data_i    in   NREQ*WIDTH*(2*VEC_LEN+1) operands; slice i = requester i {VecA,VecB,Bias}
//  req_ready_o   out  NREQ                     one-hot grant; valid&ready = accepted this cycle
//  req_lock_i    in   NREQ                     hold grant on requester i (CALC_ARB_LOCK_EN only)
//  calc_valid_o  out  1                        operand on calc_data_o valid
//  calc_data_o   out  WIDTH*(2*VEC_LEN+1)      operand to calc unit
//  calc_result_i in   WIDTH                    calc unit result
//  res_valid_o   out  NREQ                     one-hot: result for requester i on res_data_o
//  res_data_o    out  WIDTH                    result word
//  busy_o        out  1                        any issue in flight in the tag pipeline
// BEHAVIOUR
//  - Reset: req_ready_o=0 that cycle, calc_valid_o=0, calc_data_o=0, res_valid_o=0, res_data_o=0,
//    busy_o=0, rr pointer=0, tag pipeline cleared, lock owner cleared.
//  - Grant (combinational): first i with req_valid_i[i]=1 searching from ptr upward, wrapping
//    NREQ-1 -> 0. At most one req_ready_o bit high; none if no valid. Ready never high when valid low.
//  - On accept by requester g at edge T: ptr <= (g+1) mod NREQ; at T+1 calc_valid_o=1,
//    calc_data_o=slice g (registered); tag {1,g} enters stage 0.
//  - No accept: calc_valid_o=0, calc_data_o holds previous value.
//  - Tag pipeline: CALC_LAT stages, shifts every cycle unconditionally; no backpressure anywhere.
//  - Return: when last tag stage valid (cycle T+1+CALC_LAT), register calc_result_i -> res_data_o
//    and res_valid_o[g]=1 at T+2+CALC_LAT for one cycle; otherwise res_valid_o=0, res_data_o holds.
//  - Total latency accept->result = CALC_LAT+2 cycles; full throughput, back-to-back issues from
//    different or same requester return in issue order, one per cycle.
//  - busy_o = OR of all tag-stage valids plus calc_valid_o (registered form acceptable, same cycle).
//  - Requester deasserting req_valid_i without accept: no effect, ptr unchanged.
//  - Reset mid-operation: in-flight results dropped; no res_valid_o for them after rst.
//  - Requesters must sink res_valid_o every cycle; the block has no result buffering.
// CONFIGURATION
//  CALC_ARB_LOCK_EN defined: on accept with req_lock_i[g]=1, g becomes lock owner; while owned, only
//    g may be granted (others see ready=0 even if g idle); lock released on first accept from g with
//    req_lock_i[g]=0 (that accept still granted), or on rst. ptr advances only on release.
//  CALC_ARB_LOCK_EN undefined: req_lock_i ignored (port present, unconnected internally); pure RR.
// TESTING
//  1 rst held 3 cycles, all valid=1 -> ready=0, calc_valid_o=0, res_valid_o=0, busy_o=0 throughout.
//  2 only req 2 valid, 1 issue, calc_result_i=16'h1234 at T+8 -> res_valid_o=4'b0100,
//    res_data_o=16'h1234 at T+9; busy_o low at T+9.
//  3 all 4 valid continuously 8 cycles -> grants 0,1,2,3,0,1,2,3; results return same order, 1/cycle.
//  4 req 3 then req 0 valid (ptr=3) -> grant 3 then 0 (wrap); ptr ends at 1.
//  5 issues in flight, rst asserted at T+4 -> no res_valid_o pulses after rst; busy_o=0 after rst.
//  6 LOCK_EN: req1 accepted with lock=1, reqs 0,2 valid -> only req1 granted 5 cycles; req1 accept
//    with lock=0 -> next grant req2. Without LOCK_EN same stimulus -> plain RR 1,2,0,...

Source files
------------

// File: rtl/calc_share_if.sv
// Handshake bundle between the layer requesters, the shared calc unit and calc_share_arbiter.
interface calc_share_if #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int VEC_LEN = 25
);
    localparam int OPW = WIDTH * (2 * VEC_LEN + 1);

    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*OPW-1:0]  req_data_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      req_lock_i;
    logic                 calc_valid_o;
    logic [OPW-1:0]       calc_data_o;
    logic [WIDTH-1:0]     calc_result_i;
    logic [NREQ-1:0]      res_valid_o;
    logic [WIDTH-1:0]     res_data_o;
    logic                 busy_o;

    modport master (
        output req_valid_i, req_data_i, req_lock_i, calc_result_i,
        input  req_ready_o, calc_valid_o, calc_data_o, res_valid_o, res_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_lock_i, calc_result_i,
        output req_ready_o, calc_valid_o, calc_data_o, res_valid_o, res_data_o, busy_o
    );
endinterface

// File: rtl/calc_share_arbiter.sv
// Round-robin share of one fixed-latency calc unit across NREQ requesters, results routed by tag.
// Optional grant locking is enabled by defining CALC_ARB_LOCK_EN.
module calc_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 16,
    parameter int VEC_LEN  = 25,
    parameter int CALC_LAT = 7
) (
    input  logic       clk,
    input  logic       rst,
    calc_share_if.slave bus
);
    localparam int OPW = WIDTH * (2 * VEC_LEN + 1);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]              ptr;
    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0]            grant;
    logic [PW-1:0]              gidx;
    logic [PW-1:0]              idx;
    logic                       found;
    logic                       accept;
    logic [OPW-1:0]             sel_data;
    // Stage 0 is the issue register itself; stage CALC_LAT lines up with calc_result_i.
    logic [CALC_LAT:0]          vld_pipe;
    logic [CALC_LAT:0][PW-1:0]  tag_pipe;
    logic [OPW-1:0]             calc_data_q;
    logic [NREQ-1:0]            res_valid_q;
    logic [WIDTH-1:0]           res_data_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        return (32'(g) == NREQ - 1) ? '0 : g + 1'b1;
    endfunction

`ifdef CALC_ARB_LOCK_EN
    logic          lock_own;
    logic [PW-1:0] lock_id;

    // While a lock is held only the owner is eligible, even when it is idle.
    always_comb begin
        elig = bus.req_valid_i;
        if (lock_own) elig = bus.req_valid_i & (NREQ'(1) << lock_id);
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock_i;
    assign elig        = bus.req_valid_i;
`endif

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign accept = found && !rst;

    always_comb begin
        grant    = '0;
        sel_data = '0;
        if (accept) grant[gidx] = 1'b1;
        for (int r = 0; r < NREQ; r++)
            if (grant[r]) sel_data = bus.req_data_i[r*OPW +: OPW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            vld_pipe    <= '0;
            tag_pipe    <= '0;
            calc_data_q <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
`ifdef CALC_ARB_LOCK_EN
            lock_own    <= 1'b0;
            lock_id     <= '0;
`endif
        end else begin
            vld_pipe <= {vld_pipe[CALC_LAT-1:0], accept};
            tag_pipe <= {tag_pipe[CALC_LAT-1:0], gidx};
            if (accept) calc_data_q <= sel_data;
            res_valid_q <= vld_pipe[CALC_LAT] ? (NREQ'(1) << tag_pipe[CALC_LAT]) : '0;
            if (vld_pipe[CALC_LAT]) res_data_q <= bus.calc_result_i;
`ifdef CALC_ARB_LOCK_EN
            // Acquiring or holding a lock freezes the pointer; releasing advances it.
            if (accept) begin
                if (bus.req_lock_i[gidx]) begin
                    lock_own <= 1'b1;
                    lock_id  <= gidx;
                end else begin
                    lock_own <= 1'b0;
                    ptr      <= next_ptr(gidx);
                end
            end
`else
            if (accept) ptr <= next_ptr(gidx);
`endif
        end
    end

    assign bus.req_ready_o  = grant;
    assign bus.calc_valid_o = vld_pipe[0];
    assign bus.calc_data_o  = calc_data_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_data_o   = res_data_q;
    assign bus.busy_o       = |vld_pipe;
endmodule

// File: tb/tb_calc_share_arbiter.sv
// Scoreboard bench for calc_share_arbiter with a behavioural fixed-latency calc unit.
module tb_calc_share_arbiter;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 16;
    localparam int VEC_LEN  = 25;
    localparam int CALC_LAT = 7;
    localparam int OPW      = WIDTH * (2 * VEC_LEN + 1);

    typedef struct packed {
        logic [NREQ-1:0]  rv;
        logic [WIDTH-1:0] rd;
        logic [31:0]      cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_share_if #(.NREQ(NREQ), .WIDTH(WIDTH), .VEC_LEN(VEC_LEN)) bus ();

    calc_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .VEC_LEN(VEC_LEN), .CALC_LAT(CALC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Calc unit model: bias plus last VecB word, CALC_LAT cycles after the operand.
    logic [WIDTH-1:0] cq [CALC_LAT];
    always @(posedge clk) begin
        cq[0] <= bus.calc_data_o[WIDTH-1:0] + bus.calc_data_o[2*WIDTH-1:WIDTH];
        for (int i = 1; i < CALC_LAT; i++) cq[i] <= cq[i-1];
    end
    assign bus.calc_result_i = cq[CALC_LAT-1];

    res_t             exp_q[$];
    res_t             obs_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    logic [NREQ-1:0]  s_ready, s_rv;
    logic             s_cv, s_busy;
    logic [OPW-1:0]   s_cd;
    logic [WIDTH-1:0] s_rd;
    logic [OPW-1:0]   ops [NREQ];

    task automatic step();
        res_t o;
        @(negedge clk);
        cyc++;
        s_ready = bus.req_ready_o;
        s_cv    = bus.calc_valid_o;
        s_cd    = bus.calc_data_o;
        s_rv    = bus.res_valid_o;
        s_rd    = bus.res_data_o;
        s_busy  = bus.busy_o;
        if (bus.res_valid_o !== '0) begin
            o.rv  = bus.res_valid_o;
            o.rd  = bus.res_data_o;
            o.cyc = 32'(cyc);
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        for (int r = 0; r < NREQ; r++) bus.req_data_i[r*OPW +: OPW] = ops[r];
    endtask

    task automatic new_ops();
        for (int r = 0; r < NREQ; r++)
            for (int w = 0; w < 2*VEC_LEN+1; w++)
                ops[r][w*WIDTH +: WIDTH] = WIDTH'($urandom);
        drive_ops();
    endtask

    task automatic expect_issue(input int g);
        res_t e;
        e.rv  = NREQ'(1) << g;
        e.rd  = ops[g][WIDTH-1:0] + ops[g][2*WIDTH-1:WIDTH];
        e.cyc = 32'(cyc + CALC_LAT + 2);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = '1;
        repeat (3) begin
            step();
            n_checks++;
            if (s_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", s_ready); end
            n_checks++;
            if (s_cv !== 1'b0 || s_cd !== '0) begin n_fail++; $display("FAIL rst_calc: got valid %b data_nonzero %b want 0", s_cv, |s_cd); end
            n_checks++;
            if (s_rv !== '0 || s_rd !== '0) begin n_fail++; $display("FAIL rst_res: got %b/%h want 0/0", s_rv, s_rd); end
            n_checks++;
            if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", s_busy); end
        end
        rst = 1'b0;
        bus.req_valid_i = '0;
    endtask

    task automatic test_single();
        new_ops();
        ops[2] = '0;
        ops[2][WIDTH-1:0] = 16'h1234;
        drive_ops();
        bus.req_valid_i = 4'b0100;
        step();
        n_checks++;
        if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", s_ready); end
        expect_issue(2);
        bus.req_valid_i = '0;
        for (int c = 1; c <= CALC_LAT + 2; c++) begin
            step();
            if (c == 1) begin
                n_checks++;
                if (s_cv !== 1'b1 || s_cd !== ops[2]) begin n_fail++; $display("FAIL single_issue: got valid %b data_ok %b want 1/1", s_cv, s_cd === ops[2]); end
            end
            if (c == CALC_LAT + 1) begin
                n_checks++;
                if (s_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi: got %b want 1", s_busy); end
            end
            if (c == CALC_LAT + 2) begin
                n_checks++;
                if (s_rv !== 4'b0100 || s_rd !== 16'h1234) begin n_fail++; $display("FAIL single_result: got %b/%h want 0100/1234", s_rv, s_rd); end
                n_checks++;
                if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_lo: got %b want 0", s_busy); end
            end
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_valid_i = '1;
        for (int i = 0; i < 8; i++) begin
            new_ops();
            step();
            n_checks++;
            if (s_ready !== NREQ'(1) << (i % NREQ)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, s_ready, NREQ'(1) << (i % NREQ)); end
            expect_issue(i % NREQ);
        end
        bus.req_valid_i = '0;
        repeat (CALC_LAT + 2) step();
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] vtab [4];
        int              gtab [4];
        vtab = '{4'b0100, 4'b1001, 4'b0001, 4'b1111};
        gtab = '{2, 3, 0, 1};
        for (int i = 0; i < 4; i++) begin
            new_ops();
            bus.req_valid_i = vtab[i];
            step();
            n_checks++;
            if (s_ready !== NREQ'(1) << gtab[i]) begin n_fail++; $display("FAIL wrap_grant[%0d]: got %b want %b", i, s_ready, NREQ'(1) << gtab[i]); end
            expect_issue(gtab[i]);
        end
        bus.req_valid_i = '0;
        repeat (CALC_LAT + 2) step();
    endtask

    task automatic test_reset_mid();
        int n_before;
        bus.req_valid_i = '1;
        repeat (3) begin new_ops(); step(); end
        bus.req_valid_i = '0;
        step();
        rst = 1'b1;
        bus.req_valid_i = '1;
        step();
        n_checks++;
        if (s_ready !== '0 || s_busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cycle: got ready %b busy %b want 0000/1", s_ready, s_busy); end
        rst = 1'b0;
        bus.req_valid_i = '0;
        n_before = obs_q.size();
        repeat (CALC_LAT + 4) begin
            step();
            n_checks++;
            if (s_rv !== '0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_rst: got res %b busy %b want 0000/0", s_rv, s_busy); end
        end
        n_checks++;
        if (obs_q.size() !== n_before) begin n_fail++; $display("FAIL mid_dropped: got %0d results want %0d", obs_q.size(), n_before); end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] vtab [9];
        logic            ltab [9];
        int              gtab [9];
        vtab = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0111, 4'b0111};
        ltab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef CALC_ARB_LOCK_EN
        gtab = '{1, 1, 1, 1, 1, -1, 1, 2, 0};
`else
        gtab = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
`endif
        new_ops();
        bus.req_valid_i = 4'b0001;
        step();
        n_checks++;
        if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_setup: got %b want 0001", s_ready); end
        expect_issue(0);
        for (int i = 0; i < 9; i++) begin
            logic [NREQ-1:0] er;
            new_ops();
            bus.req_valid_i = vtab[i];
            bus.req_lock_i  = ltab[i] ? 4'b0010 : 4'b0000;
            step();
            er = (gtab[i] < 0) ? '0 : NREQ'(1) << gtab[i];
            n_checks++;
            if (s_ready !== er) begin n_fail++; $display("FAIL lock_grant[%0d]: got %b want %b", i, s_ready, er); end
            if (gtab[i] >= 0) expect_issue(gtab[i]);
        end
        bus.req_valid_i = '0;
        bus.req_lock_i  = '0;
        repeat (CALC_LAT + 2) step();
    endtask

    task automatic test_scoreboard();
        res_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_missing: got no result want %b/%h at cycle %0d", e.rv, e.rd, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL sb_result: got %b/%h at cycle %0d want %b/%h at cycle %0d", o.rv, o.rd, o.cyc, e.rv, e.rd, e.cyc); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL sb_extra: got %0d unexpected results want 0", obs_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_lock_i  = '0;
        new_ops();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_lock();
        test_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
